// File: rtl/shift_unit_pkg.sv
// Shared definitions for the shift unit and the write-back data mux.
// Holds the shift-op encodings, the FSM state encoding and the default data width.
package shift_unit_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        SHIFTOP_LSL = 2'b00,
        SHIFTOP_LSR = 2'b01,
        SHIFTOP_ASR = 2'b10,
        SHIFTOP_ROR = 2'b11
    } shiftop_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIN  = 2'b10
    } shift_state_e;

endpackage

// File: rtl/shift_unit_if.sv
// Request/result bundle between a shift requester and the shift unit.
// The slave side produces shifted_value/shift for the write-back mux.
interface shift_unit_if #(
    parameter int WIDTH = shift_unit_pkg::DEFAULT_WIDTH
);
    import shift_unit_pkg::*;

    logic             start;
    logic [WIDTH-1:0] operand;
    logic [7:0]       amount;
    shiftop_e         shiftop;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] shifted_value;
    logic             shift;

    modport master (
        output start,
        output operand,
        output amount,
        output shiftop,
        input  busy,
        input  done,
        input  shifted_value,
        input  shift
    );

    modport slave (
        input  start,
        input  operand,
        input  amount,
        input  shiftop,
        output busy,
        output done,
        output shifted_value,
        output shift
    );

endinterface

// File: rtl/shift_step.sv
// Combinational single-bit shift/rotate step used once per RUN cycle.
module shift_step
    import shift_unit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] value,
    input  shiftop_e         op,
    output logic [WIDTH-1:0] next_value
);

    always_comb begin
        next_value = value;
        case (op)
            SHIFTOP_LSL: next_value = {value[WIDTH-2:0], 1'b0};
            SHIFTOP_LSR: next_value = {1'b0, value[WIDTH-1:1]};
            SHIFTOP_ASR: next_value = {value[WIDTH-1], value[WIDTH-1:1]};
            SHIFTOP_ROR: next_value = {value[0], value[WIDTH-1:1]};
            default:     next_value = value;
        endcase
    end

endmodule

// File: rtl/shift_unit.sv
// Iterative shifter: one bit position per clock, result handed to write-back
// with a single-cycle shift select.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   ST_IDLE | waiting for start; result register holds last value
//   ST_RUN  | stepping shifted_value once per cycle, counter counting down
//   ST_FIN  | result valid; done/shift high for exactly this cycle
module shift_unit
    import shift_unit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    shift_unit_if.slave  bus
);

    localparam int          CNT_W   = $clog2(WIDTH) + 1;
    localparam logic [31:0] WIDTH_U = 32'(WIDTH);

    shift_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] value_q, value_d;
    shiftop_e         op_q, op_d;

    logic [31:0]      amount_ext;
    logic [CNT_W-1:0] n_eff;
    logic [WIDTH-1:0] step_value;

    assign amount_ext = 32'(bus.amount);

    // Rotates wrap modulo WIDTH; plain shifts saturate at WIDTH.
    always_comb begin
        if (bus.shiftop == SHIFTOP_ROR) begin
            n_eff = CNT_W'(amount_ext % WIDTH_U);
        end else if (amount_ext >= WIDTH_U) begin
            n_eff = CNT_W'(WIDTH_U);
        end else begin
            n_eff = CNT_W'(amount_ext);
        end
    end

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .value      (value_q),
        .op         (op_q),
        .next_value (step_value)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            value_q <= '0;
            op_q    <= SHIFTOP_LSL;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            value_q <= value_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        value_d = value_q;
        op_d    = op_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    value_d = bus.operand;
                    op_d    = bus.shiftop;
                    cnt_d   = n_eff;
                    state_d = (n_eff != '0) ? ST_RUN : ST_FIN;
                end
            end
            ST_RUN: begin
                value_d = step_value;
                cnt_d   = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.busy          = (state_q != ST_IDLE);
    assign bus.done          = (state_q == ST_FIN);
    assign bus.shift         = (state_q == ST_FIN);
    assign bus.shifted_value = value_q;

endmodule
